// File: rtl/axi_lite_req_arbiter_if.sv
// AXI4-Lite bus bundle between the request arbiter (master)
// and the register-bank slave.
interface axi_lite_req_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_lite_req_arbiter.sv
// Two-requester round-robin arbiter sequencing AXI4-Lite accesses.
// Optional AXI_LITE_ARB_ADDR_CHECK_EN: out-of-range addresses get SLVERR.
module axi_lite_req_arbiter #(
  parameter int C_ADDR_WIDTH = 4,
  parameter int C_DATA_WIDTH = 32,
  parameter int NUM_REGS     = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    req0_valid,
  input  logic                    req0_write,
  input  logic [C_ADDR_WIDTH-1:0] req0_addr,
  input  logic [31:0]             req0_wdata,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic                    req1_write,
  input  logic [C_ADDR_WIDTH-1:0] req1_addr,
  input  logic [31:0]             req1_wdata,
  output logic                    req1_ready,
  output logic                    rsp0_valid,
  output logic [31:0]             rsp0_rdata,
  output logic [1:0]              rsp0_resp,
  output logic                    rsp1_valid,
  output logic [31:0]             rsp1_rdata,
  output logic [1:0]              rsp1_resp,
  axi_lite_req_arbiter_if.master  m_axi
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t state, state_nx;

  logic                    last_grant;
  logic                    owner;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]             wdata_q;
  logic                    aw_done;
  logic                    w_done;
  logic [31:0]             rdata_q;
  logic [1:0]              resp_q;

  logic                    gnt0;
  logic                    gnt1;
  logic                    sel_write;
  logic [C_ADDR_WIDTH-1:0] sel_addr;
  logic [31:0]             sel_wdata;
  logic                    bad_addr;
  logic                    take;
  logic                    awvalid;
  logic                    wvalid;
  logic                    bready;
  logic                    arvalid;
  logic                    rready;

  // Tie goes to whoever was not served last.
  assign gnt0 = req0_valid && (!req1_valid || last_grant);
  assign gnt1 = req1_valid && (!req0_valid || !last_grant);

  assign sel_write = gnt1 ? req1_write : req0_write;
  assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
  assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;

`ifdef AXI_LITE_ARB_ADDR_CHECK_EN
  assign bad_addr =
    32'(sel_addr[C_ADDR_WIDTH-1:2]) >= 32'(NUM_REGS);
`else
  assign bad_addr = 1'b0;
`endif

  // Next state, grants and bus handshake outputs.
  always_comb begin
    state_nx   = state;
    take       = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt0 || gnt1) begin
          take       = 1'b1;
          req0_ready = gnt0;
          req1_ready = gnt1;
          if (bad_addr)       state_nx = DONE;
          else if (sel_write) state_nx = WR;
          else                state_nx = RD_ADDR;
        end
      end
      WR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || m_axi.awready) &&
            (w_done  || m_axi.wready))
          state_nx = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (m_axi.bvalid) state_nx = DONE;
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (m_axi.arready) state_nx = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (m_axi.rvalid) state_nx = DONE;
      end
      DONE: begin
        rsp0_valid = !owner;
        rsp1_valid = owner;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register, captured request and response data.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rdata_q    <= '0;
      resp_q     <= '0;
    end else begin
      state <= state_nx;
      if (take) begin
        owner      <= gnt1;
        last_grant <= gnt1;
        addr_q     <= sel_addr;
        wdata_q    <= sel_wdata;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
        if (bad_addr) begin
          resp_q  <= 2'b10;
          rdata_q <= '0;
        end
      end
      if (state == WR) begin
        if (m_axi.awready) aw_done <= 1'b1;
        if (m_axi.wready)  w_done  <= 1'b1;
      end
      if (state == WR_RESP && m_axi.bvalid) begin
        resp_q  <= m_axi.bresp;
        rdata_q <= '0;
      end
      if (state == RD_DATA && m_axi.rvalid) begin
        resp_q  <= m_axi.rresp;
        rdata_q <= m_axi.rdata;
      end
    end
  end

  assign m_axi.awaddr  = {addr_q[C_ADDR_WIDTH-1:2], 2'b00};
  assign m_axi.araddr  = {addr_q[C_ADDR_WIDTH-1:2], 2'b00};
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;

  assign rsp0_rdata = rdata_q;
  assign rsp1_rdata = rdata_q;
  assign rsp0_resp  = resp_q;
  assign rsp1_resp  = resp_q;

endmodule
